// File: rtl/alu_pkg.sv
// alu_pkg: shared ALUop, alu_sel and funct encodings for the execute stage
package alu_pkg;
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_LUI   = 3'b111;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_ILL = 4'b1111;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALUop + funct to 4-bit ALU operation decoder
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_sel
);
  // Fixed ALUops map directly; R-type defers to funct, unknown funct is illegal
  always_comb begin
    alu_sel = OP_ILL;
    case (alu_op)
      ALUOP_ADD: alu_sel = OP_ADD;
      ALUOP_SUB: alu_sel = OP_SUB;
      ALUOP_AND: alu_sel = OP_AND;
      ALUOP_OR:  alu_sel = OP_OR;
      ALUOP_SLT: alu_sel = OP_SLT;
      ALUOP_XOR: alu_sel = OP_XOR;
      ALUOP_LUI: alu_sel = OP_LUI;
      default:
        case (funct)
          FN_ADD:  alu_sel = OP_ADD;
          FN_SUB:  alu_sel = OP_SUB;
          FN_AND:  alu_sel = OP_AND;
          FN_OR:   alu_sel = OP_OR;
          FN_XOR:  alu_sel = OP_XOR;
          FN_NOR:  alu_sel = OP_NOR;
          FN_SLT:  alu_sel = OP_SLT;
          FN_SLL:  alu_sel = OP_SLL;
          FN_SRL:  alu_sel = OP_SRL;
          default: alu_sel = OP_ILL;
        endcase
    endcase
  end
endmodule

// File: rtl/exec_alu_stage.sv
// exec_alu_stage: EX-stage ALU + branch target adder, registered once; ALU_OVERFLOW_EN adds overflow output
module exec_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] pc_added,
  input  logic [DATA_W-1:0] imm_ext,
  output logic [OP_W-1:0]   alu_sel,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [DATA_W-1:0] branch_target,
`ifdef ALU_OVERFLOW_EN
  output logic              overflow,
`endif
  output logic              illegal
);
  localparam int SH_W = $clog2(DATA_W);
  logic [DATA_W-1:0] sum, diff, result_d, result_q, target_q;
  logic zero_q, illegal_q;
  alu_ctrl_dec u_dec (.alu_op(alu_op), .funct(funct), .alu_sel(alu_sel));
  assign sum  = op1 + op2;
  assign diff = op1 - op2;
  // ALU datapath; illegal and unlisted codes produce 0
  always_comb begin
    result_d = '0;
    case (alu_sel)
      OP_ADD: result_d = sum;
      OP_SUB: result_d = diff;
      OP_AND: result_d = op1 & op2;
      OP_OR:  result_d = op1 | op2;
      OP_XOR: result_d = op1 ^ op2;
      OP_NOR: result_d = ~(op1 | op2);
      OP_SLT: result_d = {{(DATA_W-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLL: result_d = op1 << op2[SH_W-1:0];
      OP_SRL: result_d = op1 >> op2[SH_W-1:0];
      OP_LUI: result_d = op2 << 16;
      default: result_d = '0;
    endcase
  end
`ifdef ALU_OVERFLOW_EN
  logic overflow_d, overflow_q;
  // Signed overflow: same-sign add / opposite-sign subtract flipping op1's sign
  always_comb begin
    overflow_d = alu_sel == OP_ADD ? (op1[DATA_W-1] == op2[DATA_W-1]) && (sum[DATA_W-1] != op1[DATA_W-1]) :
                 alu_sel == OP_SUB ? (op1[DATA_W-1] != op2[DATA_W-1]) && (diff[DATA_W-1] != op1[DATA_W-1]) : 1'b0;
  end
  // Overflow flag register, held with the rest of the bank
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else if (en) overflow_q <= overflow_d;
  end
  assign overflow = overflow_q;
`endif
  // EX/MEM output bank: reset wins, en=0 holds
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      target_q  <= '0;
      illegal_q <= 1'b0;
    end else if (en) begin
      result_q  <= result_d;
      zero_q    <= result_d == '0;
      target_q  <= pc_added + (imm_ext << 2);
      illegal_q <= alu_sel == OP_ILL;
    end
  end
  assign result        = result_q;
  assign zero          = zero_q;
  assign branch_target = target_q;
  assign illegal       = illegal_q;
endmodule

// File: tb/tb_exec_alu_stage.sv
// tb_exec_alu_stage: scoreboard bench with a behavioural model; honours ALU_OVERFLOW_EN
module tb_exec_alu_stage;
  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [31:0] tgt;
    logic        ill;
    logic        ovf;
  } exp_t;
  logic clk = 0, rst = 0, en = 0;
  logic [2:0] alu_op = 0;
  logic [5:0] funct = 0;
  logic [31:0] op1 = 0, op2 = 0, pc_added = 0, imm_ext = 0;
  logic [3:0] alu_sel;
  logic [31:0] result, branch_target;
  logic zero, illegal;
  logic overflow;
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  exp_t cur;
  exec_alu_stage dut (
    .clk(clk), .rst(rst), .en(en), .alu_op(alu_op), .funct(funct),
    .op1(op1), .op2(op2), .pc_added(pc_added), .imm_ext(imm_ext),
    .alu_sel(alu_sel), .result(result), .zero(zero), .branch_target(branch_target),
`ifdef ALU_OVERFLOW_EN
    .overflow(overflow),
`endif
    .illegal(illegal)
  );
`ifndef ALU_OVERFLOW_EN
  assign overflow = 1'b0;
`endif
  always #5 clk = ~clk;
  function automatic logic [3:0] ref_sel(input logic [2:0] op, input logic [5:0] fn);
    logic [3:0] alu_tab [8] = '{4'h2, 4'h6, 4'hF, 4'h0, 4'h1, 4'h7, 4'h3, 4'h8};
    if (op != 3'd2) return alu_tab[op];
    case (fn)
      6'd32: return 4'h2;
      6'd34: return 4'h6;
      6'd36: return 4'h0;
      6'd37: return 4'h1;
      6'd38: return 4'h3;
      6'd39: return 4'hC;
      6'd42: return 4'h7;
      6'd0:  return 4'h4;
      6'd2:  return 4'h5;
      default: return 4'hF;
    endcase
  endfunction
  function automatic exp_t ref_model(input logic [3:0] s, input logic [31:0] a, b, pc, imm);
    exp_t e;
    longint sa = longint'($signed(a)), sb = longint'($signed(b)), w = 0;
    logic [31:0] r;
    r = 0;
    case (s)
      4'h2: begin r = 32'(a + b); w = sa + sb; end
      4'h6: begin r = 32'(a - b); w = sa - sb; end
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h3: r = a ^ b;
      4'hC: r = ~(a | b);
      4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h4: r = 32'(a * (64'd1 << b[4:0]));
      4'h5: r = 32'(a / (64'd1 << b[4:0]));
      4'h8: r = 32'(b * 32'h10000);
      default: r = 0;
    endcase
    e.res  = r;
    e.zero = (r == 0);
    e.tgt  = 32'(pc + imm * 4);
    e.ill  = (s == 4'hF);
    e.ovf  = (s == 4'h2 || s == 4'h6) && (w > 64'sd2147483647 || w < -64'sd2147483648);
    return e;
  endfunction
  task automatic step(input logic r, e, input logic [2:0] op, input logic [5:0] fn,
                      input logic [31:0] a, b, pc, imm);
    logic [3:0] s;
    @(negedge clk);
    rst = r; en = e; alu_op = op; funct = fn; op1 = a; op2 = b; pc_added = pc; imm_ext = imm;
    s = ref_sel(op, fn);
    #1;
    n_chk++;
    if (alu_sel !== s) begin
      n_fail++;
      $display("FAIL alu_sel op=%b fn=%b got=%h exp=%h", op, fn, alu_sel, s);
    end
    if (r) cur = '{res: 0, zero: 1, tgt: 0, ill: 0, ovf: 0};
    else if (e) cur = ref_model(s, a, b, pc, imm);
    q.push_back(cur);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_chk++;
      if (result !== x.res || zero !== x.zero || branch_target !== x.tgt || illegal !== x.ill
`ifdef ALU_OVERFLOW_EN
          || overflow !== x.ovf
`endif
         ) begin
        n_fail++;
        $display("FAIL outputs got res=%h z=%b tgt=%h ill=%b ovf=%b exp res=%h z=%b tgt=%h ill=%b ovf=%b",
                 result, zero, branch_target, illegal, overflow, x.res, x.zero, x.tgt, x.ill, x.ovf);
      end
    end
  end
  function automatic logic [31:0] rnd_word();
    logic [31:0] sp [5] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
  endfunction
  initial begin
    logic [5:0] fns [9] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0, 6'd2};
    cur = '{res: 0, zero: 1, tgt: 0, ill: 0, ovf: 0};
    step(1, 1, 3'b010, 6'd32, 32'd9, 32'd9, 32'd4, 32'd4);
    step(1, 0, 3'b000, 6'd0, 32'd1, 32'd2, 32'd3, 32'd4);
    step(0, 1, 3'b010, 6'b100000, 32'd5, 32'd7, 32'd0, 32'd0);
    step(0, 1, 3'b001, 6'd0, 32'h1234, 32'h1234, 32'd0, 32'd0);
    step(0, 1, 3'b000, 6'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0);
    step(0, 1, 3'b010, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
    step(0, 1, 3'b010, 6'b111111, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
    step(0, 1, 3'b011, 6'd0, 32'hF0F0, 32'hFF00, 32'h00000104, 32'hFFFFFFFE);
    step(0, 0, 3'b111, 6'd5, 32'h55, 32'hABCD, 32'h1000, 32'h10);
    step(0, 0, 3'b010, 6'd39, 32'h0, 32'h0, 32'h2000, 32'h3);
    step(0, 1, 3'b111, 6'd5, 32'h55, 32'hABCD, 32'h1000, 32'h40000001);
    step(1, 0, 3'b000, 6'd0, 32'hFFFFFFFF, 32'd1, 32'h1, 32'h1);
    step(0, 1, 3'b001, 6'd0, 32'h80000000, 32'd1, 32'h1, 32'h1);
    for (int i = 0; i < 400; i++) begin
      logic [5:0] fn;
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
      step($urandom_range(0, 29) == 0, $urandom_range(0, 4) != 0, 3'($urandom), fn,
           rnd_word(), rnd_word(), rnd_word(), rnd_word());
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
